// File: rtl/store_monitor.sv
// Watches processor stores and reaches a pass/fail/timeout verdict.
// Every store seen while running is also captured in a small log FIFO.
module store_monitor #(
    parameter logic [31:0] EXP_ADDR       = 32'd84,
    parameter logic [31:0] EXP_DATA       = 32'd7,
    parameter logic [31:0] ALLOW_ADDR     = 32'd80,
    parameter int unsigned TIMEOUT_CYCLES = 30,
    parameter int unsigned LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        log_rd,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [7:0]  store_count,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_ovf
);

    localparam int unsigned AW = $clog2(LOG_DEPTH);

    typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

    state_e      state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, pass_q, fail_q, timeout_q, ovf_q;
    logic        hit, allowed;

    logic [AW:0]   wr_q, rd_q;
    logic [31:0]   addr_mem [LOG_DEPTH];
    logic [31:0]   data_mem [LOG_DEPTH];
    logic          empty, full, push, pop, wr_en;

    // Kept as plain logic so an X/Z operand falls through to the failing branch.
    assign hit     = (dataadr == EXP_ADDR) && (writedata == EXP_DATA);
    assign allowed = (dataadr == ALLOW_ADDR);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        if (state_q == StRun) begin
            cyc_d = cyc_q + 32'd1;
            if (memwrite) begin
                if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
                if (hit) state_d = StPass;
                else if (allowed) state_d = StRun;
                else state_d = StFail;
            end
            // A verdicting store on the same cycle wins over the timeout.
            if (state_d == StRun && cyc_q == TIMEOUT_CYCLES - 1) state_d = StTimeout;
        end
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push  = (state_q == StRun) && memwrite;
    assign pop   = log_rd && !empty;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            cyc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            done_q    <= (state_d != StRun);
            pass_q    <= (state_d == StPass);
            fail_q    <= (state_d == StFail);
            timeout_q <= (state_d == StTimeout);
            if (push && full && !pop) ovf_q <= 1'b1;
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            addr_mem[wr_q[AW-1:0]] <= dataadr;
            data_mem[wr_q[AW-1:0]] <= writedata;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign store_count = cnt_q;
    assign log_valid   = !empty;
    assign log_addr    = empty ? 32'd0 : addr_mem[rd_q[AW-1:0]];
    assign log_data    = empty ? 32'd0 : data_mem[rd_q[AW-1:0]];
    assign log_ovf     = ovf_q;

endmodule
